// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter.
// Optional build macro: CRITICAL_WORD_FIRST_EN (see cache_fill_arbiter.sv).
package cache_fill_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    FILL   = 3'd2,
    TAG    = 3'd3,
    RESUME = 3'd4
  } state_t;

  // Which cache currently owns the memory for a refill.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // 16-bit words in one cache block.
  localparam int WORDS_PER_BLOCK = 8;

  // Word index inside a block lives in address bits [3:1];
  // bits [3:0] together form the byte offset within the block.
  localparam int WORD_IDX_W   = 3;
  localparam int WORD_OFS_LSB = 1;
  localparam int WORD_OFS_MSB = 3;
  localparam int BLOCK_OFS_W  = 4;

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Issue/return/outstanding bookkeeping for one block refill, plus the
// word address generation for both the memory read side and the cache
// write side. A non-zero rot rotates the word order (critical word first).
// Optional build macro: CRITICAL_WORD_FIRST_EN changes busy_hold so the
// owner's busy flag only covers the critical (first returned) word.
module cache_fill_arbiter_fill_counter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          active,
  input  logic                          mem_data_valid,
  input  logic [ADDR_W-BLOCK_OFS_W-1:0] block,
  input  logic [WORD_IDX_W-1:0]         rot,
  output logic                          issue,
  output logic [ADDR_W-1:0]             issue_addr,
  output logic                          ret,
  output logic [ADDR_W-1:0]             ret_addr,
  output logic                          last_ret,
  output logic                          busy_hold
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]      OUT_ONE  = OUT_W'(1);
  localparam logic [WORD_IDX_W-1:0] IDX_ONE  = WORD_IDX_W'(1);
  localparam logic [WORD_IDX_W-1:0] IDX_LAST = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  // 3-bit counters plus a done flag each, so a finished side never wraps.
  logic [WORD_IDX_W-1:0] iss_cnt_reg;
  logic [WORD_IDX_W-1:0] ret_cnt_reg;
  logic                  iss_done_reg;
  logic                  ret_done_reg;
  logic [OUT_W-1:0]      outstanding_reg;
  logic [WORD_IDX_W-1:0] iss_idx;
  logic [WORD_IDX_W-1:0] ret_idx;

  assign issue    = active && !iss_done_reg && (outstanding_reg < OUT_MAX);
  assign ret      = active && mem_data_valid && !ret_done_reg;
  assign last_ret = ret && (ret_cnt_reg == IDX_LAST);

  // 3-bit addition wraps modulo the block, which is exactly the rotation.
  assign iss_idx    = iss_cnt_reg + rot;
  assign ret_idx    = ret_cnt_reg + rot;
  assign issue_addr = {block, iss_idx, 1'b0};
  assign ret_addr   = {block, ret_idx, 1'b0};

`ifdef CRITICAL_WORD_FIRST_EN
  // Busy only until the critical word has landed in the data array.
  assign busy_hold = (ret_cnt_reg == '0) && !ret_done_reg;
`else
  assign busy_hold = 1'b1;
`endif

  // Counter state; a new grant clears everything for the next block.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      iss_cnt_reg     <= '0;
      ret_cnt_reg     <= '0;
      iss_done_reg    <= 1'b0;
      ret_done_reg    <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      if (issue) begin
        iss_cnt_reg <= iss_cnt_reg + IDX_ONE;
        if (iss_cnt_reg == IDX_LAST) iss_done_reg <= 1'b1;
      end
      if (ret) begin
        ret_cnt_reg <= ret_cnt_reg + IDX_ONE;
        if (ret_cnt_reg == IDX_LAST) ret_done_reg <= 1'b1;
      end
      // Simultaneous issue and return cancel out.
      if (issue && !ret) begin
        outstanding_reg <= outstanding_reg + OUT_ONE;
      end else if (!issue && ret && (outstanding_reg != '0)) begin
        outstanding_reg <= outstanding_reg - OUT_ONE;
      end
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single main memory between the I-cache and D-cache:
// write-through stores first, then refills with round-robin between the
// two caches when both miss. Each refill reads one 8-word block, streams
// the returned words into the owner's data array, then writes its tag.
// Optional build macro: CRITICAL_WORD_FIRST_EN -- start the block at the
// missed word and release the owner's busy after the critical word.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [ADDR_W-1:0] d_wr_data,
  output logic              d_wr_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_fsm_busy,
  output logic              d_fsm_busy,
  output logic              i_write_data_array,
  output logic              d_write_data_array,
  output logic              i_write_tag_array,
  output logic              d_write_tag_array
);

  state_t            state_reg, state_next;
  owner_t            owner_reg, owner_next;
  owner_t            last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] miss_addr_reg, miss_addr_next;

  logic              grant_valid;
  owner_t            grant_owner;
  logic [ADDR_W-1:0] grant_addr;

  logic              fill_start;
  logic              fill_active;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              ret;
  logic [ADDR_W-1:0] ret_addr;
  logic              last_ret;
  logic              busy_hold;
  logic [WORD_IDX_W-1:0] rot;

  // Owner-relative strobes, steered to the owning cache below.
  logic       own_busy;
  logic       own_wda;
  logic       own_wta;
  logic [1:0] owner_onehot;
  logic [1:0] busy_vec;
  logic [1:0] wda_vec;
  logic [1:0] wta_vec;

`ifdef CRITICAL_WORD_FIRST_EN
  assign rot = miss_addr_reg[WORD_OFS_MSB:WORD_OFS_LSB];
`else
  assign rot = '0;
`endif

  assign fill_active = (state_reg == FILL);
  assign fill_start  = (state_reg == IDLE) && (state_next == FILL);

  cache_fill_arbiter_fill_counter #(
    .ADDR_W          (ADDR_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_fill_counter (
    .clk            (clk),
    .rst            (rst),
    .start          (fill_start),
    .active         (fill_active),
    .mem_data_valid (mem_data_valid),
    .block          (miss_addr_reg[ADDR_W-1:BLOCK_OFS_W]),
    .rot            (rot),
    .issue          (issue),
    .issue_addr     (issue_addr),
    .ret            (ret),
    .ret_addr       (ret_addr),
    .last_ret       (last_ret),
    .busy_hold      (busy_hold)
  );

  // Miss arbitration: a pending store blocks any grant; with two misses
  // the cache that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_D;
    if (!d_wr_req) begin
      if (i_miss && d_miss) begin
        grant_valid = 1'b1;
        grant_owner = (last_grant_reg == OWN_I) ? OWN_D : OWN_I;
      end else if (i_miss) begin
        grant_valid = 1'b1;
        grant_owner = OWN_I;
      end else if (d_miss) begin
        grant_valid = 1'b1;
        grant_owner = OWN_D;
      end
    end
    grant_addr = (grant_owner == OWN_I) ? i_miss_addr : d_miss_addr;
  end

  // Next-state and output decode; every output idles at 0.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    miss_addr_next  = miss_addr_reg;
    d_wr_done       = 1'b0;
    mem_enable      = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    fill_addr       = '0;
    own_busy        = 1'b0;
    own_wda         = 1'b0;
    own_wta         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_wr_req) begin
          state_next = WRITE;
        end else if (grant_valid) begin
          state_next      = FILL;
          owner_next      = grant_owner;
          last_grant_next = grant_owner;
          miss_addr_next  = grant_addr;
        end
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_done  = 1'b1;
        state_next = IDLE;
      end
      FILL: begin
        mem_enable = issue;
        mem_addr   = issue ? issue_addr : '0;
        own_busy   = busy_hold;
        own_wda    = ret;
        fill_addr  = ret ? ret_addr : '0;
        if (last_ret) state_next = TAG;
      end
      TAG: begin
        own_wta    = 1'b1;
        fill_addr  = miss_addr_reg;
        state_next = RESUME;
      end
      RESUME: begin
        // Gap cycle so the requester can re-probe and drop its miss.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any fill without a tag write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_I;
      last_grant_reg <= OWN_D;
      miss_addr_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      miss_addr_reg  <= miss_addr_next;
    end
  end

  // Index 0 is the I-cache (OWN_I), index 1 the D-cache (OWN_D).
  assign owner_onehot = (owner_reg == OWN_D) ? 2'b10 : 2'b01;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cache
    assign busy_vec[gi] = own_busy & owner_onehot[gi];
    assign wda_vec[gi]  = own_wda  & owner_onehot[gi];
    assign wta_vec[gi]  = own_wta  & owner_onehot[gi];
  end

  assign i_fsm_busy         = busy_vec[0];
  assign d_fsm_busy         = busy_vec[1];
  assign i_write_data_array = wda_vec[0];
  assign d_write_data_array = wda_vec[1];
  assign i_write_tag_array  = wta_vec[0];
  assign d_write_tag_array  = wta_vec[1];

endmodule
